vrf_arbiter_mc: RTL and testbench
=================================

Name: vrf_arbiter_mc

Overview:
- Multi-channel successor to the single-router VRF arbiter.
- Arbitrates NUM_CH independent requesters onto one true-dual-port VRF BRAM:
  - port A serves reads only;
  - port B serves writes only.
- Each port has its own round-robin arbiter, so one read and one write can complete per cycle.
- Read data returns through a latency-matched pipeline tagged by channel. Sits between the router crossbar and the VRF BRAM.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- VRF_ADDR_WIDTH, 10, BRAM address width.
- VRF_DATA_WIDTH, 1024, BRAM data width.
- RD_LAT, 1, BRAM port-A read latency in cycles (1 or 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- bram_a_addr_o  output  VRF_ADDR_WIDTH  port A address
- bram_a_dout_i  input  VRF_DATA_WIDTH  port A read data
- bram_a_din_o  output  VRF_DATA_WIDTH  port A write data, tied 0
- bram_a_en_o  output  1  port A enable
- bram_a_we_o  output  1  port A write enable, tied 0
- bram_b_addr_o  output  VRF_ADDR_WIDTH  port B address
- bram_b_dout_i  input  VRF_DATA_WIDTH  unused
- bram_b_din_o  output  VRF_DATA_WIDTH  port B write data
- bram_b_en_o  output  1  port B enable
- bram_b_we_o  output  1  port B write enable
- rd_req_i  input  NUM_CH  per-channel read request
- rd_addr_i  input  NUM_CH*VRF_ADDR_WIDTH  read addresses; channel c occupies slice c
- rd_gnt_o  output  NUM_CH  one-hot read grant
- rd_valid_o  output  NUM_CH  one-hot read-data valid
- rd_data_o  output  VRF_DATA_WIDTH  shared read data
- wr_req_i  input  NUM_CH  per-channel write request
- wr_addr_i  input  NUM_CH*VRF_ADDR_WIDTH  write addresses
- wr_data_i  input  NUM_CH*VRF_DATA_WIDTH  write data
- wr_gnt_o  output  NUM_CH  one-hot write grant

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - rr pointers rd_ptr and wr_ptr = 0;
  - read pipeline valid bits cleared;
  - during rst all grants, enables, we and rd_valid_o = 0;
  - address/data outputs = 0.
- Grant is combinational from req and the registered pointer, issued in the same cycle.
- Arbitration, per port:
  - search channels starting at ptr, ascending, wrapping NUM_CH-1 -> 0;
  - the first requesting channel c wins;
  - at most one grant bit is set.
  - On a grant, ptr <= (c+1) mod NUM_CH at the clock edge. With no request, ptr holds.
- Handshake:
  - the requester holds req and addr/data stable until it sees gnt high at a clock edge;
  - the transfer is accepted on that edge;
  - req may stay high for back-to-back transfers;
  - the next grant to the same channel follows rr order.
  - Withdrawing req before gnt is permitted; no transfer occurs.
- Read:
  - when rd_gnt_o[c] is set, bram_a_en_o = 1 and bram_a_addr_o = slice c of rd_addr_i;
  - a one-hot channel tag enters an RD_LAT-deep shift pipeline;
  - exactly RD_LAT cycles later rd_valid_o[c] = 1 and rd_data_o = bram_a_dout_i;
  - rd_data_o = 0 when no valid.
  - Full throughput: one read per cycle, tags never collide.
- Write:
  - when wr_gnt_o[c] is set, bram_b_en_o = bram_b_we_o = 1;
  - bram_b_addr_o and bram_b_din_o = slice c;
  - commit occurs on that edge.
  - Write latency is 0 cycles after grant.
- Simultaneous read and write to the same address on the same cycle: port A returns the pre-write data (BRAM read-first), unless the optional feature is enabled.
- Reset asserted mid-read: pipeline tags are flushed and no rd_valid_o is emitted for reads in flight. Reads in flight after reset release are lost; requesters must reissue.
- Single requester: granted every cycle it requests; the pointer always moves past it.

Optional Feature:
- Macro: ARB_RAW_BYPASS_EN.
- Defined:
  - a same-cycle read grant and write grant with equal addresses sets a bypass flag;
  - the write data is captured into an RD_LAT-deep data pipeline;
  - the matching rd_data_o returns the new write data instead of bram_a_dout_i.
- Undefined: no bypass logic; the old data is returned.

Test Plan:
- Reset: hold rst 2 cycles with all req=1 -> all gnt/en/we/rd_valid 0; after release, the first rd_gnt and wr_gnt go to channel 0.
- Round-robin fairness: NUM_CH=4, all rd_req_i=4'b1111 for 8 cycles -> grants 0,1,2,3,0,1,2,3; rd_valid_o follows with the same order, delayed RD_LAT.
- Read data path: preload addr 5=0xA5.., ch2 reads addr 5 with RD_LAT=2 -> rd_valid_o=4'b0100 two cycles after grant, rd_data_o=0xA5...
- Concurrent ports: ch1 writes addr 7=0x3C while ch3 reads addr 9 -> both granted the same cycle; the later read of addr 7 returns 0x3C.
- RAW: ch0 writes addr 4=0x11 (old 0x22) and ch1 reads addr 4 in the same cycle -> 0x22 without ARB_RAW_BYPASS_EN, 0x11 with it.
- Reset mid-flight: RD_LAT=2, assert rst the cycle after a read grant -> no rd_valid_o; pointers back to 0.

Source files
------------

// File: rtl/vrf_arbiter_mc_if.sv
// Bundle of the requester-side and BRAM-side signals of vrf_arbiter_mc.
// The slave modport is the arbiter's view; the master modport is the crossbar/BRAM view.
interface vrf_arbiter_mc_if #(
  parameter int NUM_CH         = 4,
  parameter int VRF_ADDR_WIDTH = 10,
  parameter int VRF_DATA_WIDTH = 1024
);
  logic [VRF_ADDR_WIDTH-1:0]        bram_a_addr_o;
  logic [VRF_DATA_WIDTH-1:0]        bram_a_dout_i;
  logic [VRF_DATA_WIDTH-1:0]        bram_a_din_o;
  logic                             bram_a_en_o;
  logic                             bram_a_we_o;
  logic [VRF_ADDR_WIDTH-1:0]        bram_b_addr_o;
  logic [VRF_DATA_WIDTH-1:0]        bram_b_dout_i;
  logic [VRF_DATA_WIDTH-1:0]        bram_b_din_o;
  logic                             bram_b_en_o;
  logic                             bram_b_we_o;
  logic [NUM_CH-1:0]                rd_req_i;
  logic [NUM_CH*VRF_ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_CH-1:0]                rd_gnt_o;
  logic [NUM_CH-1:0]                rd_valid_o;
  logic [VRF_DATA_WIDTH-1:0]        rd_data_o;
  logic [NUM_CH-1:0]                wr_req_i;
  logic [NUM_CH*VRF_ADDR_WIDTH-1:0] wr_addr_i;
  logic [NUM_CH*VRF_DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_CH-1:0]                wr_gnt_o;

  modport slave (
    output bram_a_addr_o, bram_a_din_o, bram_a_en_o, bram_a_we_o,
    output bram_b_addr_o, bram_b_din_o, bram_b_en_o, bram_b_we_o,
    output rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o,
    input  bram_a_dout_i, bram_b_dout_i,
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i
  );

  modport master (
    input  bram_a_addr_o, bram_a_din_o, bram_a_en_o, bram_a_we_o,
    input  bram_b_addr_o, bram_b_din_o, bram_b_en_o, bram_b_we_o,
    input  rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o,
    output bram_a_dout_i, bram_b_dout_i,
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i
  );
endinterface

// File: rtl/vrf_arbiter_mc.sv
// Multi-channel VRF arbiter: round-robin reads on BRAM port A, writes on port B.
// Optional read-after-write bypass is enabled by defining ARB_RAW_BYPASS_EN.
module vrf_arbiter_mc #(
  parameter int NUM_CH         = 4,
  parameter int VRF_ADDR_WIDTH = 10,
  parameter int VRF_DATA_WIDTH = 1024,
  parameter int RD_LAT         = 1
) (
  input  logic                clk,
  input  logic                rst,
  vrf_arbiter_mc_if.slave     bus
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = VRF_ADDR_WIDTH;
  localparam int DW = VRF_DATA_WIDTH;

  logic [PW-1:0]                 rd_ptr_q, wr_ptr_q;
  logic [PW-1:0]                 rd_next_d, wr_next_d;
  logic [NUM_CH-1:0]             rd_gnt_d, wr_gnt_d;
  logic [AW-1:0]                 rd_addr_d, wr_addr_d;
  logic [DW-1:0]                 wr_data_d;
  logic [RD_LAT-1:0][NUM_CH-1:0] tag_q;
  logic [NUM_CH-1:0]             rd_valid_d;
  logic [DW-1:0]                 rd_sel_d;

  // First requester at or after ptr, ascending with wrap-around.
  function automatic logic [NUM_CH-1:0] rr_grant(input logic [NUM_CH-1:0] req,
                                                 input logic [PW-1:0]     ptr);
    logic [NUM_CH-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      else               idx = idx;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
    return g;
  endfunction

  // Grants, selected address/data and next pointers.
  always_comb begin
    rd_gnt_d  = rst ? '0 : rr_grant(bus.rd_req_i, rd_ptr_q);
    wr_gnt_d  = rst ? '0 : rr_grant(bus.wr_req_i, wr_ptr_q);
    rd_addr_d = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rd_next_d = rd_ptr_q;
    wr_next_d = wr_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_gnt_d[c]) begin
        rd_addr_d = bus.rd_addr_i[c*AW +: AW];
        rd_next_d = (c == NUM_CH - 1) ? '0 : PW'(c + 1);
      end else begin
        rd_addr_d = rd_addr_d;
      end
      if (wr_gnt_d[c]) begin
        wr_addr_d = bus.wr_addr_i[c*AW +: AW];
        wr_data_d = bus.wr_data_i[c*DW +: DW];
        wr_next_d = (c == NUM_CH - 1) ? '0 : PW'(c + 1);
      end else begin
        wr_addr_d = wr_addr_d;
      end
    end
  end

  // Round-robin pointers and the read-tag shift pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      rd_ptr_q <= rd_next_d;
      wr_ptr_q <= wr_next_d;
      tag_q[0] <= rd_gnt_d;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef ARB_RAW_BYPASS_EN
  logic [RD_LAT-1:0]         byp_q;
  logic [RD_LAT-1:0][DW-1:0] bdat_q;

  // Same-cycle read/write to one address: carry the new write data alongside the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q  <= '0;
      bdat_q <= '0;
    end else begin
      byp_q[0]  <= (|rd_gnt_d) && (|wr_gnt_d) && (rd_addr_d == wr_addr_d);
      bdat_q[0] <= wr_data_d;
      for (int i = 1; i < RD_LAT; i++) begin
        byp_q[i]  <= byp_q[i-1];
        bdat_q[i] <= bdat_q[i-1];
      end
    end
  end

  assign rd_sel_d = byp_q[RD_LAT-1] ? bdat_q[RD_LAT-1] : bus.bram_a_dout_i;
`else
  assign rd_sel_d = bus.bram_a_dout_i;
`endif

  assign rd_valid_d        = rst ? '0 : tag_q[RD_LAT-1];
  assign bus.rd_valid_o    = rd_valid_d;
  assign bus.rd_data_o     = (|rd_valid_d) ? rd_sel_d : '0;
  assign bus.rd_gnt_o      = rd_gnt_d;
  assign bus.wr_gnt_o      = wr_gnt_d;
  assign bus.bram_a_en_o   = |rd_gnt_d;
  assign bus.bram_a_addr_o = rd_addr_d;
  assign bus.bram_a_we_o   = 1'b0;
  assign bus.bram_a_din_o  = '0;
  assign bus.bram_b_en_o   = |wr_gnt_d;
  assign bus.bram_b_we_o   = |wr_gnt_d;
  assign bus.bram_b_addr_o = wr_addr_d;
  assign bus.bram_b_din_o  = wr_data_d;
endmodule

// File: tb/tb_vrf_arbiter_mc.sv
// Randomized bench for vrf_arbiter_mc against a transaction-level reference model
// with a read-first BRAM; directed sequences cover reset, fairness, RAW and mid-flight reset.
module tb_vrf_arbiter_mc;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int MAXC = 4096;

  logic clk;
  logic rst;
  vrf_arbiter_mc_if #(.NUM_CH(N), .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW)) bus ();

  vrf_arbiter_mc #(.NUM_CH(N), .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW), .RD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM model with LAT-cycle port-A latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] bp  [0:1];
  always @(posedge clk) begin
    if (bus.bram_a_en_o) bp[0] <= mem[bus.bram_a_addr_o];
    bp[1] <= bp[0];
    if (bus.bram_b_en_o && bus.bram_b_we_o) mem[bus.bram_b_addr_o] <= bus.bram_b_din_o;
  end
  assign bus.bram_a_dout_i = bp[LAT-1];
  assign bus.bram_b_dout_i = '0;

  // Reference state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [N-1:0]  exp_v [0:MAXC-1];
  logic [DW-1:0] exp_d [0:MAXC-1];
  int            rd_ptr_m, wr_ptr_m, cyc;
  int            vec_cnt, err_cnt;

  logic [N-1:0]  rd_req_v, wr_req_v, last_rd_g, last_wr_g;
  logic [AW-1:0] rd_addr_v [N];
  logic [AW-1:0] wr_addr_v [N];
  logic [DW-1:0] wr_data_v [N];

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step(input logic r);
    int            rc, wc;
    logic [N-1:0]  eg_rd, eg_wr;
    logic [AW-1:0] ea_rd, ea_wr;
    logic [DW-1:0] ed_wr, rdat;
    rst = r;
    bus.rd_req_i = rd_req_v;
    bus.wr_req_i = wr_req_v;
    for (int c = 0; c < N; c++) begin
      bus.rd_addr_i[c*AW +: AW] = rd_addr_v[c];
      bus.wr_addr_i[c*AW +: AW] = wr_addr_v[c];
      bus.wr_data_i[c*DW +: DW] = wr_data_v[c];
    end
    @(negedge clk);
    rc = r ? -1 : rr_winner(rd_req_v, rd_ptr_m);
    wc = r ? -1 : rr_winner(wr_req_v, wr_ptr_m);
    eg_rd = '0; eg_wr = '0; ea_rd = '0; ea_wr = '0; ed_wr = '0;
    if (rc >= 0) begin eg_rd[rc] = 1'b1; ea_rd = rd_addr_v[rc]; end
    if (wc >= 0) begin eg_wr[wc] = 1'b1; ea_wr = wr_addr_v[wc]; ed_wr = wr_data_v[wc]; end
    if (r) for (int i = 0; i < LAT; i++) exp_v[cyc + i] = '0;
    check_val("rd_gnt", DW'(bus.rd_gnt_o), DW'(eg_rd));
    check_val("wr_gnt", DW'(bus.wr_gnt_o), DW'(eg_wr));
    check_val("a_en", DW'(bus.bram_a_en_o), DW'(rc >= 0));
    check_val("a_addr", DW'(bus.bram_a_addr_o), DW'(ea_rd));
    check_val("a_we_din", DW'(bus.bram_a_we_o) | bus.bram_a_din_o, '0);
    check_val("b_en_we", DW'({bus.bram_b_en_o, bus.bram_b_we_o}), (wc >= 0) ? DW'(3) : DW'(0));
    check_val("b_addr", DW'(bus.bram_b_addr_o), DW'(ea_wr));
    check_val("b_din", bus.bram_b_din_o, ed_wr);
    check_val("rd_valid", DW'(bus.rd_valid_o), DW'(exp_v[cyc]));
    check_val("rd_data", bus.rd_data_o, (exp_v[cyc] != '0) ? exp_d[cyc] : '0);
    if (rc >= 0) begin
      rdat = ref_mem[ea_rd];
`ifdef ARB_RAW_BYPASS_EN
      if (wc >= 0 && ea_wr == ea_rd) rdat = ed_wr;
`endif
      exp_v[cyc + LAT] = eg_rd;
      exp_d[cyc + LAT] = rdat;
      rd_ptr_m = (rc + 1) % N;
    end
    if (wc >= 0) begin
      ref_mem[ea_wr] = ed_wr;
      wr_ptr_m = (wc + 1) % N;
    end
    if (r) begin rd_ptr_m = 0; wr_ptr_m = 0; end
    last_rd_g = eg_rd;
    last_wr_g = eg_wr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req_v = '0;
    wr_req_v = '0;
  endtask

  // Requesters hold until granted, occasionally withdraw, and raise new requests at random.
  task automatic gen();
    for (int c = 0; c < N; c++) begin
      if (rd_req_v[c] && !last_rd_g[c]) begin
        if ($urandom_range(0, 9) == 0) rd_req_v[c] = 1'b0;
      end else begin
        rd_req_v[c]  = ($urandom_range(0, 1) == 1);
        rd_addr_v[c] = AW'($urandom_range(0, 15));
      end
      if (wr_req_v[c] && !last_wr_g[c]) begin
        if ($urandom_range(0, 9) == 0) wr_req_v[c] = 1'b0;
      end else begin
        wr_req_v[c]  = ($urandom_range(0, 1) == 1);
        wr_addr_v[c] = AW'($urandom_range(0, 15));
        wr_data_v[c] = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; cyc = 0; rd_ptr_m = 0; wr_ptr_m = 0;
    last_rd_g = '0; last_wr_g = '0;
    for (int i = 0; i < MAXC; i++) begin exp_v[i] = '0; exp_d[i] = '0; end
    for (int a = 0; a < (1<<AW); a++) begin
      mem[a]     = {32'hC0DE0000, 32'(a)};
      ref_mem[a] = {32'hC0DE0000, 32'(a)};
    end
    mem[5] = {16{4'hA, 4'h5}};
    ref_mem[5] = {16{4'hA, 4'h5}};
    bp[0] = '0; bp[1] = '0;
    for (int c = 0; c < N; c++) begin
      rd_addr_v[c] = AW'(c + 16); wr_addr_v[c] = AW'(c + 32); wr_data_v[c] = DW'(c + 64'h100);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset with all requests high, then first grants go to channel 0.
    rd_req_v = '1; wr_req_v = '1;
    step(1'b1); step(1'b1);
    step(1'b0);

    // Fairness: all reads requested for 8 cycles.
    idle(); step(1'b1); rd_req_v = '1;
    for (int i = 0; i < 8; i++) step(1'b0);
    idle(); for (int i = 0; i < LAT; i++) step(1'b0);

    // Channel 2 reads the preloaded pattern at address 5.
    rd_req_v = 4'b0100; rd_addr_v[2] = AW'(5); step(1'b0);
    idle(); for (int i = 0; i < LAT; i++) step(1'b0);

    // Concurrent write ch1 -> addr 7 and read ch3 <- addr 9, then read addr 7 back.
    wr_req_v = 4'b0010; wr_addr_v[1] = AW'(7); wr_data_v[1] = DW'(8'h3C);
    rd_req_v = 4'b1000; rd_addr_v[3] = AW'(9); step(1'b0);
    idle(); rd_req_v = 4'b0001; rd_addr_v[0] = AW'(7); step(1'b0);
    idle(); for (int i = 0; i < LAT; i++) step(1'b0);

    // RAW at address 4: old 0x22, same-cycle write of 0x11.
    wr_req_v = 4'b0001; wr_addr_v[0] = AW'(4); wr_data_v[0] = DW'(8'h22); step(1'b0);
    wr_req_v = 4'b0001; wr_data_v[0] = DW'(8'h11);
    rd_req_v = 4'b0010; rd_addr_v[1] = AW'(4); step(1'b0);
    idle(); for (int i = 0; i < LAT; i++) step(1'b0);

    // Reset the cycle after a read grant: the read is dropped, pointers return to 0.
    rd_req_v = 4'b0100; rd_addr_v[2] = AW'(5); wr_req_v = 4'b0100; step(1'b0);
    idle(); step(1'b1);
    for (int i = 0; i < LAT; i++) step(1'b0);
    rd_req_v = '1; wr_req_v = '1; step(1'b0);
    idle(); for (int i = 0; i < LAT; i++) step(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      gen();
      step(1'b0);
    end
    idle(); for (int i = 0; i < LAT + 1; i++) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
